// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor built from 4-bit lookahead groups.
// Optional output clamping on signed overflow is enabled by defining CLA_SATURATE_EN.
module pipelined_cla_addsub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int GROUPS = WIDTH / 4;
  localparam int BASE   = GROUPS / STAGES;
  localparam int EXTRA  = GROUPS % STAGES;
  localparam int LAST   = STAGES - 1;

  // First group handled by stage s; lower stages absorb the remainder groups.
  function automatic int grp_lo(input int s);
    return s * BASE + ((s < EXTRA) ? s : EXTRA);
  endfunction

  // 4-bit lookahead group: returns {carry_out, sum[3:0]}.
  function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y, input logic ci);
    logic [3:0] g, p;
    logic [4:0] c;
    g    = x & y;
    p    = x ^ y;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    return {c[4], p ^ c[3:0]};
  endfunction

`ifdef CLA_SATURATE_EN
  function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] s, input logic o,
                                                input logic a_msb);
    if (o) return a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    return s;
  endfunction
`endif

  logic [WIDTH-1:0] a_p   [STAGES];
  logic [WIDTH-1:0] b_p   [STAGES];
  logic [WIDTH-1:0] sum_p [STAGES];
  logic             c_p   [STAGES];
  logic             vld_p [STAGES];
  logic             ovf_p;

  logic [WIDTH-1:0] src_a  [STAGES];
  logic [WIDTH-1:0] src_b  [STAGES];
  logic [WIDTH-1:0] src_s  [STAGES];
  logic             src_c  [STAGES];
  logic [WIDTH-1:0] nx_sum [STAGES];
  logic             nx_c   [STAGES];
  logic [WIDTH-1:0] fin_sum;
  logic             nx_ovf;
  logic [WIDTH-1:0] grp_s;
  logic [4:0]       grp_r;
  logic             grp_c;
  logic             advance;

  assign out_valid = vld_p[LAST];
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;

  always_comb begin
    grp_s = '0;
    grp_r = '0;
    grp_c = 1'b0;
    // Stage 0 sees the port operands with B already inverted for subtract.
    src_a[0] = a;
    src_b[0] = sub ? ~b : b;
    src_s[0] = '0;
    src_c[0] = sub | cin;
    for (int s = 1; s < STAGES; s++) begin
      src_a[s] = a_p[s-1];
      src_b[s] = b_p[s-1];
      src_s[s] = sum_p[s-1];
      src_c[s] = c_p[s-1];
    end
    for (int s = 0; s < STAGES; s++) begin
      grp_c = src_c[s];
      grp_s = src_s[s];
      for (int g = 0; g < GROUPS; g++) begin
        if (g >= grp_lo(s) && g < grp_lo(s + 1)) begin
          grp_r = cla4(src_a[s][4*g +: 4], src_b[s][4*g +: 4], grp_c);
          grp_s[4*g +: 4] = grp_r[3:0];
          grp_c = grp_r[4];
        end
      end
      nx_sum[s] = grp_s;
      nx_c[s]   = grp_c;
    end
    nx_ovf = (src_a[LAST][WIDTH-1] == src_b[LAST][WIDTH-1]) &&
             (nx_sum[LAST][WIDTH-1] != src_a[LAST][WIDTH-1]);
`ifdef CLA_SATURATE_EN
    fin_sum = saturate(nx_sum[LAST], nx_ovf, src_a[LAST][WIDTH-1]);
`else
    fin_sum = nx_sum[LAST];
`endif
  end

  // Stage registers: valid bits are reset, data just follows the global advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) vld_p[s] <= 1'b0;
    end else if (advance) begin
      vld_p[0] <= in_valid;
      for (int s = 1; s < STAGES; s++) vld_p[s] <= vld_p[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      for (int s = 0; s < STAGES; s++) begin
        a_p[s]   <= src_a[s];
        b_p[s]   <= src_b[s];
        c_p[s]   <= nx_c[s];
        sum_p[s] <= (s == LAST) ? fin_sum : nx_sum[s];
      end
      ovf_p <= nx_ovf;
    end
  end

  // Outputs read as zero whenever nothing valid is presented, including during reset.
  assign sum  = out_valid ? sum_p[LAST] : '0;
  assign cout = out_valid & c_p[LAST];
  assign ovf  = out_valid & ovf_p;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Scoreboard bench for pipelined_cla_addsub: directed 16-bit/2-stage vectors plus
// 4-bit/1-stage and 32-bit/8-stage random streams against an arithmetic reference.
module tb_pipelined_cla_addsub;

`ifdef CLA_SATURATE_EN
  localparam logic [15:0] EXP_POS_OVF = 16'h7FFF;
  localparam logic [15:0] EXP_NEG_OVF = 16'h8000;
`else
  localparam logic [15:0] EXP_POS_OVF = 16'h8000;
  localparam logic [15:0] EXP_NEG_OVF = 16'h7FFF;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    logic [31:0] s;
    logic        co;
    logic        ov;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t qm[$];
  exp_t q4[$];
  exp_t q32[$];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", nm, got, exp);
  endtask

  // Reference: plain wide arithmetic, returns {ovf, cout, sum}.
  function automatic logic [65:0] ref_op(input int w, input logic [63:0] x, input logic [63:0] y,
                                         input logic ci, input logic sb);
    logic [64:0] full;
    logic [63:0] mask, be, s;
    logic        co, ov;
    mask = (64'd1 << w) - 64'd1;
    be   = (sb ? ~y : y) & mask;
    full = {1'b0, x & mask} + {1'b0, be} + {64'd0, (sb ? 1'b1 : ci)};
    s    = full[63:0] & mask;
    co   = full[w];
    ov   = (x[w-1] == be[w-1]) && (s[w-1] != x[w-1]);
`ifdef CLA_SATURATE_EN
    if (ov) s = x[w-1] ? (64'd1 << (w-1)) : ((64'd1 << (w-1)) - 64'd1);
`endif
    return {ov, co, s};
  endfunction

  // Main DUT: WIDTH=16, STAGES=2
  logic        rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [15:0] a, b, sum;

  pipelined_cla_addsub #(.WIDTH(16), .STAGES(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .cout(cout), .ovf(ovf)
  );

  // Sweep DUTs
  logic        rst_s;
  logic        w4_iv, w4_ir, w4_cin, w4_sub, w4_ov, w4_or, w4_co, w4_of;
  logic [3:0]  w4_a, w4_b, w4_sum;
  logic        w32_iv, w32_ir, w32_cin, w32_sub, w32_ov, w32_or, w32_co, w32_of;
  logic [31:0] w32_a, w32_b, w32_sum;

  pipelined_cla_addsub #(.WIDTH(4), .STAGES(1)) dut4 (
    .clk(clk), .rst(rst_s), .in_valid(w4_iv), .in_ready(w4_ir), .a(w4_a), .b(w4_b),
    .cin(w4_cin), .sub(w4_sub), .out_valid(w4_ov), .out_ready(w4_or), .sum(w4_sum),
    .cout(w4_co), .ovf(w4_of)
  );

  pipelined_cla_addsub #(.WIDTH(32), .STAGES(8)) dut32 (
    .clk(clk), .rst(rst_s), .in_valid(w32_iv), .in_ready(w32_ir), .a(w32_a), .b(w32_b),
    .cin(w32_cin), .sub(w32_sub), .out_valid(w32_ov), .out_ready(w32_or), .sum(w32_sum),
    .cout(w32_co), .ovf(w32_of)
  );

  // Monitors: pop one expectation per retiring result
  always @(negedge clk) begin : mon_main
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (qm.size() == 0) chk("main_unexpected_output", {46'd0, ovf, cout, sum}, 64'd0);
      else begin
        e = qm.pop_front();
        chk("main_result", {46'd0, ovf, cout, sum}, {46'd0, e.ov, e.co, e.s[15:0]});
        if (e.lat) chk("main_latency", 64'(cyc - e.cyc), 64'd2);
      end
    end
  end

  always @(negedge clk) begin : mon_w4
    exp_t e;
    if (!rst_s && w4_ov && w4_or) begin
      if (q4.size() == 0) chk("w4_unexpected_output", {58'd0, w4_of, w4_co, w4_sum}, 64'd0);
      else begin
        e = q4.pop_front();
        chk("w4_result", {58'd0, w4_of, w4_co, w4_sum}, {58'd0, e.ov, e.co, e.s[3:0]});
        chk("w4_latency", 64'(cyc - e.cyc), 64'd1);
      end
    end
  end

  always @(negedge clk) begin : mon_w32
    exp_t e;
    if (!rst_s && w32_ov && w32_or) begin
      if (q32.size() == 0) chk("w32_unexpected_output", {30'd0, w32_of, w32_co, w32_sum}, 64'd0);
      else begin
        e = q32.pop_front();
        chk("w32_result", {30'd0, w32_of, w32_co, w32_sum}, {30'd0, e.ov, e.co, e.s});
        chk("w32_latency", 64'(cyc - e.cyc), 64'd8);
      end
    end
  end

  // Drive one operation on the main DUT; called just after a rising edge.
  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic ci, input logic sb,
                      input logic [15:0] es, input logic eco, input logic eov, input bit lat);
    int   n;
    exp_t e;
    a = x; b = y; cin = ci; sub = sb; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 64'(in_ready), 64'd1);
    else begin
      e.s = {16'd0, es}; e.co = eco; e.ov = eov; e.cyc = cyc; e.lat = lat;
      qm.push_back(e);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain_main(input string nm);
    int n;
    n = 0;
    while (qm.size() != 0 && n < 30) begin
      @(posedge clk);
      n++;
    end
    #1 chk(nm, 64'(qm.size()), 64'd0);
  endtask

  task automatic check_idle(input string nm);
    chk({nm, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({nm, "_outputs"}, {46'd0, ovf, cout, sum}, 64'd0);
    chk({nm, "_in_ready"}, 64'(in_ready), 64'd1);
  endtask

  task automatic run_main;
    // Directed single operations
    send(16'h1234, 16'h0F0F, 1'b0, 1'b0, 16'h2143, 1'b0, 1'b0, 1'b1);
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, EXP_POS_OVF, 1'b0, 1'b1, 1'b1);
    send(16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b1);
    send(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1);
    send(16'h8000, 16'h0001, 1'b0, 1'b1, EXP_NEG_OVF, 1'b1, 1'b1, 1'b1);
    send(16'h0009, 16'h0003, 1'b0, 1'b1, 16'h0006, 1'b1, 1'b0, 1'b1);
    drain_main("directed_drain");

    // Backpressure: stall three cycles once the first result is presented
    send(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
    send(16'h0002, 16'h0002, 1'b0, 1'b0, 16'h0004, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b0;
    fork
      begin
        send(16'h0003, 16'h0003, 1'b0, 1'b0, 16'h0006, 1'b0, 1'b0, 1'b0);
        send(16'h0004, 16'h0004, 1'b0, 1'b0, 16'h0008, 1'b0, 1'b0, 1'b0);
      end
      begin
        repeat (3) begin
          @(negedge clk);
          chk("stall_in_ready", 64'(in_ready), 64'd0);
          chk("stall_out_valid", 64'(out_valid), 64'd1);
          chk("stall_sum_hold", 64'(sum), 64'h0002);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain_main("backpressure_drain");

    // Reset with two operations in flight
    send(16'h0011, 16'h0022, 1'b0, 1'b0, 16'h0033, 1'b0, 1'b0, 1'b1);
    send(16'h0100, 16'h0200, 1'b0, 1'b0, 16'h0300, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    qm.delete();
    @(negedge clk);
    check_idle("midreset");
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle("after_reset");
    @(posedge clk);
    #1;
    send(16'h0010, 16'h0020, 1'b0, 1'b0, 16'h0030, 1'b0, 1'b0, 1'b1);
    drain_main("reset_drain");
  endtask

  task automatic run_w4;
    logic [31:0] rnd;
    logic [65:0] r;
    exp_t        e;
    for (int i = 0; i < 1000; i++) begin
      rnd = $urandom;
      w4_a = rnd[3:0]; w4_b = rnd[7:4]; w4_cin = rnd[8]; w4_sub = rnd[9]; w4_iv = 1'b1;
      r = ref_op(4, {60'd0, w4_a}, {60'd0, w4_b}, w4_cin, w4_sub);
      e.s = r[31:0]; e.co = r[64]; e.ov = r[65]; e.cyc = cyc; e.lat = 1'b1;
      q4.push_back(e);
      @(posedge clk);
      #1;
    end
    w4_iv = 1'b0;
    repeat (5) @(posedge clk);
    #1 chk("w4_drain", 64'(q4.size()), 64'd0);
  endtask

  task automatic run_w32;
    logic [31:0] ra, rb, rc;
    logic [65:0] r;
    exp_t        e;
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom; rb = $urandom; rc = $urandom;
      if (i < 4) begin
        ra = (i < 2) ? 32'h7FFF_FFFF : 32'h8000_0000;
        rb = (i == 3) ? 32'h0000_0001 : 32'hFFFF_FFFF;
      end
      w32_a = ra; w32_b = rb; w32_cin = rc[0]; w32_sub = rc[1]; w32_iv = 1'b1;
      r = ref_op(32, {32'd0, w32_a}, {32'd0, w32_b}, w32_cin, w32_sub);
      e.s = r[31:0]; e.co = r[64]; e.ov = r[65]; e.cyc = cyc; e.lat = 1'b1;
      q32.push_back(e);
      @(posedge clk);
      #1;
    end
    w32_iv = 1'b0;
    repeat (12) @(posedge clk);
    #1 chk("w32_drain", 64'(q32.size()), 64'd0);
  endtask

  initial begin
    rst = 1'b1; rst_s = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    w4_iv = 1'b0; w4_or = 1'b1; w4_a = '0; w4_b = '0; w4_cin = 1'b0; w4_sub = 1'b0;
    w32_iv = 1'b0; w32_or = 1'b1; w32_a = '0; w32_b = '0; w32_cin = 1'b0; w32_sub = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    @(posedge clk);
    #1 rst = 1'b0; rst_s = 1'b0;
    fork
      run_main();
      run_w4();
      run_w32();
    join
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_chk);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipelined_cla_addsub.md
# pipelined_cla_addsub

Parametrised, pipelined carry-lookahead adder/subtractor built from 4-bit lookahead groups, with carries registered between pipeline stages. It extends the single-cycle 4-bit lookahead adder to arbitrary widths and adds a subtract mode, signed overflow detection and a valid/ready streaming interface. It sits in the datapath as the ALU's wide add/sub unit and accepts one operation per cycle.

## Interface
- `WIDTH`, 16, operand width in bits; must be a multiple of 4 and at least 4.
- `STAGES`, 2, number of register stages (the latency), 1..WIDTH/4.
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: operands and mode are valid this cycle.
- `in_ready` output 1: the block accepts the input this cycle.
- `a` input WIDTH: operand A.
- `b` input WIDTH: operand B.
- `cin` input 1: carry-in; used in add mode only.
- `sub` input 1: 0 selects add, 1 selects subtract.
- `out_valid` output 1: the result is valid.
- `out_ready` input 1: the consumer takes the result this cycle.
- `sum` output WIDTH: the result.
- `cout` output 1: carry-out in add mode; no-borrow flag (1 means a ≥ b unsigned) in subtract mode.
- `ovf` output 1: two's-complement signed overflow.

## Operation
- Add: {cout,sum} = a + b + cin.
- Subtract: {cout,sum} = a + ~b + 1. `cin` is ignored.
- `ovf` = (a_msb == beff_msb) && (sum_msb != a_msb), where beff is the B operand after the subtract inversion. It is computed from the unsaturated result.
- Datapath:
  - WIDTH/4 groups, each computing generate/propagate terms and full lookahead carries as in the 4-bit form.
  - Groups are split across STAGES as evenly as possible. When the split is uneven, the lower stages take the extra group.
  - Each stage registers its finished sum bits, its group carry-out, and the not-yet-used upper operand bits together with `sub`.
- Handshake:
  - Global advance = !out_valid || out_ready. All stage registers load only when advance is 1.
  - in_ready = advance.
  - A transfer occurs when in_valid && in_ready.
  - The valid bit shifts through the stages. Bubbles are not compressed.
- While out_valid=1 and out_ready=0, `sum`, `cout` and `ovf` hold stable and no stage changes.
- Results leave in issue order. Throughput is one result per cycle when out_ready is held at 1.

## Timing
- Reset: all stage valid bits are 0, out_valid=0, sum=0, cout=0, ovf=0, in_ready=1. This applies immediately and asynchronously.
- Reset during operation discards every in-flight operation. After `rst` falls, the first accepted input appears STAGES cycles later.
- Latency: an input accepted at edge N produces out_valid=1 with its result after edge N+STAGES−1+1. That is, the result is visible in the cycle following STAGES rising edges, provided there is no stall.
- Simultaneous consume and accept (out_valid && out_ready && in_valid): the new result advances and the old one retires in the same cycle, with no bubble.
- in_valid=0 while advancing inserts a bubble, and out_valid drops to 0 for one cycle later.
- STAGES=1: the block is a fully combinational adder followed by one output register.
- Wrap-around: with saturation off, results are modulo 2^WIDTH (for example, 0xFFFF+1 gives 0x0000 with cout=1).

## Configuration
- Macro: `CLA_SATURATE_EN`.
- When defined, and ovf=1, `sum` clamps:
  - to 0x7F…F (most positive) if the true result is positive (a_msb=0);
  - to 0x80…0 (most negative) if it is negative.
- With saturation enabled, `ovf` and `cout` are still reported unchanged, and latency is unchanged.
- When undefined, `sum` wraps with no clamping logic.

## Test plan
All scenarios use WIDTH=16, STAGES=2 unless noted.
- **Add:** a=0x1234, b=0x0F0F, cin=0, sub=0 → sum=0x2143, cout=0, ovf=0; out_valid rises 2 cycles after acceptance.
- **Carry and signed overflow:**
  - 0xFFFF + 0x0001 → sum=0x0000, cout=1, ovf=0.
  - 0x7FFF + 0x0001 → sum=0x8000 (0x7FFF with CLA_SATURATE_EN), ovf=1.
- **Subtract:**
  - 0x0005 − 0x0007 → sum=0xFFFE, cout=0, ovf=0.
  - 0x8000 − 0x0001 → sum=0x7FFF (0x8000 with CLA_SATURATE_EN), cout=1, ovf=1.
- **Backpressure:** stream 4 back-to-back adds (1+1, 2+2, 3+3, 4+4) and hold out_ready=0 for 3 cycles after the first result → in_ready=0 during the stall, sum holds at 0x0002, and all four results (0x0002, 0x0004, 0x0006, 0x0008) emerge in order with no loss or duplication.
- **Reset mid-flight:** accept 2 operations, assert rst for 1 cycle before either emerges → out_valid stays 0, outputs are 0, and a following add of 0x0010+0x0020 yields 0x0030 2 cycles after acceptance.
- **Parameter sweep:** WIDTH=4, STAGES=1 and WIDTH=32, STAGES=8 with 1000 random operations against a reference model → results match bit-exactly, with latency equal to STAGES.
